best_tracker: RTL and testbench

Downstream consumer of the 160-bit hash-distance metric stage. Accepts a stream of (metric, tag) candidates, keeps the best (largest metric, i.e. most matching leading bits) seen since the last start, and emits a report whenever a new best reaches a programmable threshold. Flags completion on a perfect match (metric 160) and exposes running best and candidate count for host polling.

---
 rtl/best_tracker_pkg.sv | 14 +
 rtl/best_tracker.sv | 121 ++++++++++++
 tb/tb_best_tracker.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/best_tracker_pkg.sv
// Shared types and constants for the best-candidate tracker.
// Metric is the leading-match bit count of a 160-bit hash comparison.
package best_tracker_pkg;

  localparam int METRIC_W = 9;
  localparam logic [METRIC_W-1:0] METRIC_MAX = 9'd160;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

endpackage

// File: rtl/best_tracker.sv
// Tracks the best (metric, tag) candidate of a search, raises reports
// for new bests at or above a threshold, and stops on a perfect match.
module best_tracker
  import best_tracker_pkg::*;
#(
  parameter int TAG_W = 64,
  parameter int CNT_W = 48
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [METRIC_W-1:0] threshold_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [METRIC_W-1:0] metric_i,
  input  logic [TAG_W-1:0]    tag_i,
  output logic                rep_valid_o,
  input  logic                rep_ready_i,
  output logic [METRIC_W-1:0] rep_metric_o,
  output logic [TAG_W-1:0]    rep_tag_o,
  output logic [METRIC_W-1:0] best_metric_o,
  output logic [TAG_W-1:0]    best_tag_o,
  output logic [CNT_W-1:0]    count_o,
  output logic                busy_o,
  output logic                done_o
);

  state_t state_q, state_d;

  logic [METRIC_W-1:0] best_metric_q;
  logic [TAG_W-1:0]    best_tag_q;
  logic [CNT_W-1:0]    count_q;
  logic [METRIC_W-1:0] thr_q;
  logic                rep_valid_q;
  logic [METRIC_W-1:0] rep_metric_q;
  logic [TAG_W-1:0]    rep_tag_q;

  logic [METRIC_W-1:0] metric;
  logic                accept;
  logic                improve;
  logic                load;
  logic                perfect;

  // Out-of-range metrics are clamped to a perfect match.
  assign metric = (metric_i > METRIC_MAX) ? METRIC_MAX : metric_i;

  assign in_ready_o = (state_q == SEARCH);
  assign busy_o     = (state_q == SEARCH);
  assign done_o     = (state_q == DONE);

  assign accept  = in_valid_i & in_ready_o;
  assign improve = accept & (metric > best_metric_q);
  assign load    = improve & (metric >= thr_q);
  assign perfect = accept & (metric == METRIC_MAX);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = SEARCH;
    end else if (perfect) begin
      state_d = DONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      best_metric_q <= '0;
      best_tag_q    <= '0;
      count_q       <= '0;
      thr_q         <= '0;
      rep_valid_q   <= 1'b0;
      rep_metric_q  <= '0;
      rep_tag_q     <= '0;
    end else if (start_i) begin
      best_metric_q <= '0;
      best_tag_q    <= '0;
      count_q       <= '0;
      thr_q         <= threshold_i;
      rep_valid_q   <= 1'b0;
      rep_metric_q  <= '0;
      rep_tag_q     <= '0;
    end else begin
      if (accept && (count_q != '1)) begin
        count_q <= count_q + CNT_W'(1);
      end
      if (improve) begin
        best_metric_q <= metric;
        best_tag_q    <= tag_i;
      end
      // A new best overwrites any unconsumed report.
      if (load) begin
        rep_valid_q  <= 1'b1;
        rep_metric_q <= metric;
        rep_tag_q    <= tag_i;
      end else if (rep_valid_q && rep_ready_i) begin
        rep_valid_q <= 1'b0;
      end
    end
  end

  assign best_metric_o = best_metric_q;
  assign best_tag_o    = best_tag_q;
  assign count_o       = count_q;
  assign rep_valid_o   = rep_valid_q;
  assign rep_metric_o  = rep_metric_q;
  assign rep_tag_o     = rep_tag_q;

  illegal_metric_a: assert property (
    @(posedge clk_i) disable iff (rst_i)
    accept |-> (metric_i <= METRIC_MAX)
  );

endmodule

// File: tb/tb_best_tracker.sv
// Scoreboard bench for best_tracker: directed scenarios plus random
// traffic, checked against a transaction-level reference model.
module tb_best_tracker;

  localparam int TAG_W = 64;
  localparam int CNT_W = 5;
  localparam int CMAX  = 31;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic [8:0]       threshold_i = '0;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [8:0]       metric_i = '0;
  logic [TAG_W-1:0] tag_i = '0;
  logic             rep_valid_o;
  logic             rep_ready_i = 1'b0;
  logic [8:0]       rep_metric_o;
  logic [TAG_W-1:0] rep_tag_o;
  logic [8:0]       best_metric_o;
  logic [TAG_W-1:0] best_tag_o;
  logic [CNT_W-1:0] count_o;
  logic             busy_o;
  logic             done_o;

  best_tracker #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .start_i(start_i),
    .threshold_i(threshold_i),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .metric_i(metric_i),
    .tag_i(tag_i),
    .rep_valid_o(rep_valid_o),
    .rep_ready_i(rep_ready_i),
    .rep_metric_o(rep_metric_o),
    .rep_tag_o(rep_tag_o),
    .best_metric_o(best_metric_o),
    .best_tag_o(best_tag_o),
    .count_o(count_o),
    .busy_o(busy_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rdy;
    logic             busy;
    logic             done;
    logic [8:0]       bm;
    logic [TAG_W-1:0] bt;
    logic [CNT_W-1:0] cnt;
    logic             rv;
    logic             chk;
    logic [8:0]       rm;
    logic [TAG_W-1:0] rt;
  } st_t;

  typedef struct {
    logic [8:0]       m;
    logic [TAG_W-1:0] t;
  } rep_t;

  st_t  st_q[$];
  rep_t rep_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: 0 idle, 1 searching, 2 finished
  int               ms = 0;
  int               mb = 0;
  logic [TAG_W-1:0] mbt = '0;
  int               mc = 0;
  int               mthr = 0;
  bit               mrv = 0;
  bit               mfresh = 1;
  int               mrm = 0;
  logic [TAG_W-1:0] mrt = '0;

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit s, input int thr,
                      input bit v, input int met,
                      input logic [TAG_W-1:0] tg, input bit rdy);
    st_t  e;
    rep_t x;
    @(posedge clk);
    #2;
    e.rdy  = (ms == 1);
    e.busy = (ms == 1);
    e.done = (ms == 2);
    e.bm   = 9'(mb);
    e.bt   = mbt;
    e.cnt  = CNT_W'(mc);
    e.rv   = mrv;
    e.chk  = mrv || mfresh;
    e.rm   = 9'(mrm);
    e.rt   = mrt;
    st_q.push_back(e);
    rst_i       = r;
    start_i     = s;
    threshold_i = 9'(thr);
    in_valid_i  = v;
    metric_i    = 9'(met);
    tag_i       = tg;
    rep_ready_i = rdy;
    if (mrv && rdy) begin
      x.m = 9'(mrm);
      x.t = mrt;
      rep_q.push_back(x);
    end
    mfresh = 0;
    if (r) begin
      ms = 0; mb = 0; mbt = '0; mc = 0; mthr = 0;
      mrv = 0; mrm = 0; mrt = '0; mfresh = 1;
    end else if (s) begin
      ms = 1; mb = 0; mbt = '0; mc = 0; mthr = thr; mrv = 0;
    end else begin
      if (mrv && rdy) mrv = 0;
      if (ms == 1 && v) begin
        mc = (mc < CMAX) ? mc + 1 : CMAX;
        if (met > mb) begin
          mb  = met;
          mbt = tg;
          if (met >= mthr) begin
            mrv = 1; mrm = met; mrt = tg;
          end
        end
        if (met == 160) ms = 2;
      end
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0, rdy);
  endtask

  st_t  me;
  rep_t mr;

  always @(negedge clk) begin
    if (st_q.size() > 0) begin
      me = st_q.pop_front();
      check("ctl", 128'({in_ready_o, busy_o, done_o}),
            128'({me.rdy, me.busy, me.done}));
      check("best", 128'({best_metric_o, best_tag_o}),
            128'({me.bm, me.bt}));
      check("count", 128'(count_o), 128'(me.cnt));
      check("rep_valid", 128'(rep_valid_o), 128'(me.rv));
      if (me.chk)
        check("rep_data", 128'({rep_metric_o, rep_tag_o}),
              128'({me.rm, me.rt}));
    end
    if (rep_valid_o && rep_ready_i) begin
      if (rep_q.size() == 0) begin
        check("rep_unexpected", 128'({rep_metric_o, rep_tag_o}), 128'(0));
        if ({rep_metric_o, rep_tag_o} == '0) begin
          n_bad++;
          $display("FAIL rep_unexpected @%0t: got transfer want none",
                   $time);
        end
      end else begin
        mr = rep_q.pop_front();
        check("rep_xfer", 128'({rep_metric_o, rep_tag_o}),
              128'({mr.m, mr.t}));
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, '0, 0);
    step(1, 0, 0, 0, 0, '0, 0);
    idle(2, 0);
    // basic search with threshold 20
    step(0, 1, 20, 0, 0, '0, 1);
    step(0, 0, 0, 1, 5, 64'd1, 1);
    step(0, 0, 0, 1, 12, 64'd2, 1);
    step(0, 0, 0, 1, 12, 64'd3, 1);
    step(0, 0, 0, 1, 25, 64'd4, 1);
    idle(3, 1);
    // overwrite while consumer stalls
    step(0, 1, 10, 0, 0, '0, 0);
    step(0, 0, 0, 1, 15, 64'hA, 0);
    step(0, 0, 0, 1, 18, 64'hB, 0);
    idle(3, 0);
    idle(3, 1);
    // ties keep the earlier tag
    step(0, 1, 0, 0, 0, '0, 1);
    step(0, 0, 0, 1, 30, 64'd7, 1);
    step(0, 0, 0, 1, 30, 64'd8, 1);
    idle(2, 1);
    // perfect match, valid held afterwards
    step(0, 0, 0, 1, 160, 64'd9, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 50, 64'd10, 1);
    step(0, 1, 0, 0, 0, '0, 1);
    idle(2, 1);
    // ready rises the same cycle a new best loads
    step(0, 1, 0, 0, 0, '0, 0);
    step(0, 0, 0, 1, 40, 64'd1, 0);
    step(0, 0, 0, 1, 50, 64'd2, 1);
    idle(1, 0);
    idle(2, 1);
    // reset mid-search with a pending report
    step(0, 1, 0, 0, 0, '0, 0);
    step(0, 0, 0, 1, 40, 64'd1, 0);
    step(1, 0, 0, 0, 0, '0, 0);
    idle(2, 0);
    // counter saturation
    step(0, 1, 5, 0, 0, '0, 1);
    for (int i = 0; i < 40; i++)
      step(0, 0, 0, 1, int'($urandom_range(0, 100)),
           {32'h0, $urandom}, bit'($urandom_range(0, 1)));
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, s, v, rd;
      int th, mt;
      r  = ($urandom_range(0, 499) == 0);
      s  = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 9) < 7);
      rd = ($urandom_range(0, 1) == 1);
      th = (($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 200)));
      mt = (($urandom_range(0, 99) == 0) ? 160
            : int'($urandom_range(0, 159)));
      step(r, s, th, v, mt, {$urandom, $urandom}, rd);
    end
    idle(4, 1);
    @(negedge clk);
    #1;
    check("drain", 128'({st_q.size(), rep_q.size()}), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
